pcie_flow_ctrl_rx: RTL and testbench

//  Receive side of DLLP flow-control handling, paired with pcie_flow_ctrl_init.

---
 rtl/pcie_flow_ctrl_rx_if.sv | 32 +++
 rtl/pcie_flow_ctrl_rx.sv | 242 ++++++++++++++++++++++++
 tb/tb_pcie_flow_ctrl_rx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_flow_ctrl_rx_if.sv
// AXI-stream beat channel carrying 2-beat DLLPs (32-bit body, then 16-bit CRC)
// into the receive-side flow-control block.
interface pcie_flow_ctrl_rx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [KEEP_WIDTH-1:0] s_axis_tkeep;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic [USER_WIDTH-1:0] s_axis_tuser;
  logic                  s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_axis_tvalid,
    output s_axis_tlast,
    output s_axis_tuser,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    input  s_axis_tuser,
    output s_axis_tready
  );
endinterface

// File: rtl/pcie_flow_ctrl_rx.sv
// Receive-side DLLP flow-control: CRC-checks 2-beat DLLPs, decodes InitFC1/InitFC2/UpdateFC
// for one VC and holds the per-type credit limits plus the FC init handshake flags.
module pcie_flow_ctrl_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3,
  parameter int VC_ID      = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  pcie_flow_ctrl_rx_if.slave     s_axis_if,
  output logic                   fc1_values_stored_o,
  output logic                   fc2_values_stored_o,
  output logic [7:0]             p_hdr_o,
  output logic [7:0]             np_hdr_o,
  output logic [7:0]             cpl_hdr_o,
  output logic [11:0]            p_data_o,
  output logic [11:0]            np_data_o,
  output logic [11:0]            cpl_data_o,
  output logic                   update_valid_o,
  output logic                   crc_err_o,
  output logic                   frame_err_o
);

  localparam logic [1:0] ST_BODY = 2'd0;
  localparam logic [1:0] ST_CRC  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [2:0] VC_SEL = 3'(VC_ID);

  // DLLP CRC: poly 0x100B, fed LSB-first from byte 0, result complemented.
  function automatic logic [15:0] pcie_datalink_crc(input logic [15:0] crc_in,
                                                   input logic [31:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    return ~c;
  endfunction

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tlast;

  assign tdata  = s_axis_if.s_axis_tdata;
  assign tkeep  = s_axis_if.s_axis_tkeep;
  assign tuser  = s_axis_if.s_axis_tuser;
  assign tvalid = s_axis_if.s_axis_tvalid;
  assign tlast  = s_axis_if.s_axis_tlast;

  logic [1:0]  state_q, state_d;
  logic [31:0] body_q, body_d;
  logic        tready_q;
  logic        fc1_q, fc1_d;
  logic        fc2_q, fc2_d;
  logic        update_q, update_d;
  logic        crc_err_q, crc_err_d;
  logic        frame_err_q, frame_err_d;

  logic        beat;
  logic [15:0] crc_raw;
  logic [15:0] crc_rev;
  logic        crc_ok;
  logic        crc_beat;
  logic [7:0]  dllp_type;
  logic [1:0]  dllp_idx;
  logic        vc_ok;
  logic        dllp_ok;
  logic        is_init1;
  logic        is_init2;
  logic        is_init;
  logic        is_upd;
  logic [7:0]  body_hdr;
  logic [11:0] body_data;

  logic [2:0]  lock_w;
  logic [2:0]  lock_set_w;
  logic [7:0]  hdr_w  [3];
  logic [11:0] data_w [3];

  // Fields that the decode never looks at; kept only so every input bit has a reader.
  logic unused_bits;
  assign unused_bits = ^{tkeep, tuser, body_q[15:14], body_q[21:20], body_q[3]};

  assign beat = tvalid && tready_q;

  always_comb begin
    crc_raw = pcie_datalink_crc(16'hFFFF, body_q);
    crc_rev = '0;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 8; j++) begin
        crc_rev[8*b + j] = crc_raw[8*b + 7 - j];
      end
    end
  end

  assign crc_ok   = (crc_rev == tdata[15:0]);
  assign crc_beat = beat && (state_q == ST_CRC) && tlast;

  assign dllp_type = body_q[7:0];
  assign dllp_idx  = dllp_type[5:4];
  assign vc_ok     = (dllp_type[2:0] == VC_SEL);
  assign is_init1  = (dllp_type[7:6] == 2'b01) && (dllp_idx != 2'd3);
  assign is_init2  = (dllp_type[7:6] == 2'b11) && (dllp_idx != 2'd3);
  assign is_upd    = (dllp_type[7:6] == 2'b10) && (dllp_idx != 2'd3);
  assign is_init   = is_init1 || is_init2;
  assign dllp_ok   = crc_beat && crc_ok && vc_ok;

  assign body_hdr  = {body_q[13:8], body_q[23:22]};
  assign body_data = {body_q[19:16], body_q[31:24]};

  always_comb begin
    state_d     = state_q;
    body_d      = body_q;
    frame_err_d = 1'b0;
    if (beat) begin
      case (state_q)
        ST_BODY: begin
          if (tlast) begin
            frame_err_d = 1'b1;
          end else begin
            body_d  = tdata[31:0];
            state_d = ST_CRC;
          end
        end
        ST_CRC: begin
          if (tlast) begin
            state_d = ST_BODY;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_DROP;
          end
        end
        ST_DROP: begin
          if (tlast) begin
            state_d = ST_BODY;
          end
        end
        default: state_d = ST_BODY;
      endcase
    end
  end

  // Per-type credit slots: index 0/1/2 = P/NP/Cpl, taken straight from type[5:4].
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_type
      logic        sel;
      logic        lock_set;
      logic        load;
      logic        lock_q;
      logic [7:0]  hdr_q;
      logic [11:0] data_q;

      assign sel      = (dllp_idx == 2'(gi));
      assign lock_set = dllp_ok && sel && is_init;
      assign load     = (lock_set && !lock_q) || (dllp_ok && sel && is_upd && fc2_q);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          lock_q <= 1'b0;
          hdr_q  <= '0;
          data_q <= '0;
        end else if (clear_i) begin
          lock_q <= 1'b0;
          hdr_q  <= '0;
          data_q <= '0;
        end else begin
          if (lock_set) begin
            lock_q <= 1'b1;
          end
          if (load) begin
            hdr_q  <= body_hdr;
            data_q <= body_data;
          end
        end
      end

      assign lock_w[gi]     = lock_q;
      assign lock_set_w[gi] = lock_set;
      assign hdr_w[gi]      = hdr_q;
      assign data_w[gi]     = data_q;
    end
  endgenerate

  // fc2 needs fc1 from an earlier DLLP, so it looks at fc1_q rather than fc1_d.
  assign fc1_d     = fc1_q || (&(lock_w | lock_set_w));
  assign fc2_d     = fc2_q || (dllp_ok && (is_init2 || is_upd) && fc1_q);
  assign update_d  = dllp_ok && is_upd && fc2_q;
  assign crc_err_d = crc_beat && !crc_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_BODY;
      body_q      <= '0;
      tready_q    <= 1'b0;
      fc1_q       <= 1'b0;
      fc2_q       <= 1'b0;
      update_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= ST_BODY;
      body_q      <= '0;
      tready_q    <= 1'b0;
      fc1_q       <= 1'b0;
      fc2_q       <= 1'b0;
      update_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      body_q      <= body_d;
      tready_q    <= 1'b1;
      fc1_q       <= fc1_d;
      fc2_q       <= fc2_d;
      update_q    <= update_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_axis_if.s_axis_tready = tready_q;

  assign fc1_values_stored_o = fc1_q;
  assign fc2_values_stored_o = fc2_q;
  assign p_hdr_o             = hdr_w[0];
  assign np_hdr_o            = hdr_w[1];
  assign cpl_hdr_o           = hdr_w[2];
  assign p_data_o            = data_w[0];
  assign np_data_o           = data_w[1];
  assign cpl_data_o          = data_w[2];
  assign update_valid_o      = update_q;
  assign crc_err_o           = crc_err_q;
  assign frame_err_o         = frame_err_q;

endmodule

// File: tb/tb_pcie_flow_ctrl_rx.sv
// Directed bench for pcie_flow_ctrl_rx: builds DLLPs with a reference CRC and checks
// credit latching, init flags, UpdateFC, CRC/framing errors, VC filtering and resets.
module tb_pcie_flow_ctrl_rx;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        fc1, fc2;
  logic [7:0]  p_hdr, np_hdr, cpl_hdr;
  logic [11:0] p_data, np_data, cpl_data;
  logic        update_valid, crc_err, frame_err;

  int vectors;
  int miscompares;

  pcie_flow_ctrl_rx_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3)) bus ();

  pcie_flow_ctrl_rx #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3), .VC_ID(0)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .clear_i             (clear),
    .s_axis_if           (bus),
    .fc1_values_stored_o (fc1),
    .fc2_values_stored_o (fc2),
    .p_hdr_o             (p_hdr),
    .np_hdr_o            (np_hdr),
    .cpl_hdr_o           (cpl_hdr),
    .p_data_o            (p_data),
    .np_data_o           (np_data),
    .cpl_data_o          (cpl_data),
    .update_valid_o      (update_valid),
    .crc_err_o           (crc_err),
    .frame_err_o         (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference DLLP CRC written as explicit tap equations for poly 0x100B,
  // LSB-first per byte, init all-ones, complemented, then bit-reversed per byte.
  function automatic logic [15:0] ref_crc(input logic [31:0] body);
    logic [15:0] r;
    logic [15:0] o;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = r[15] ^ body[i];
      r  = {r[14:12], r[11] ^ fb, r[10:3], r[2] ^ fb, r[1], r[0] ^ fb, fb};
    end
    r = ~r;
    for (int j = 0; j < 8; j++) begin
      o[j]     = r[7 - j];
      o[8 + j] = r[15 - j];
    end
    return o;
  endfunction

  function automatic logic [31:0] make_body(input logic [7:0] typ, input logic [7:0] hdr,
                                            input logic [11:0] dat);
    logic [31:0] b;
    b        = '0;
    b[7:0]   = typ;
    b[13:8]  = hdr[7:2];
    b[23:22] = hdr[1:0];
    b[19:16] = dat[11:8];
    b[31:24] = dat[7:0];
    return b;
  endfunction

  // Presents one beat, waits (bounded) for tready, returns #1 after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = last ? 4'h3 : 4'hF;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    while (bus.s_axis_tready !== 1'b1 && guard < 16) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 16) begin
      vectors++; miscompares++;
      $display("FAIL tready_timeout got tready=%b required 1", bus.s_axis_tready);
    end
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_dllp(input logic [7:0] typ, input logic [7:0] hdr,
                           input logic [11:0] dat, input logic [15:0] crc_flip);
    logic [31:0] body;
    logic [15:0] crc;
    body = make_body(typ, hdr, dat);
    crc  = ref_crc(body) ^ crc_flip;
    send_beat(body, 1'b0);
    send_beat({16'h0000, crc}, 1'b1);
    $display("dllp type=%02h hdr=%02h data=%03h body=%08h crc=%04h", typ, hdr, dat, body, crc);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (bus.s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready got %b required 0", bus.s_axis_tready); end
    vectors++;
    if ({fc1, fc2, update_valid, crc_err, frame_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags got %b required 00000", {fc1, fc2, update_valid, crc_err, frame_err});
    end
    vectors++;
    if ({p_hdr, np_hdr, cpl_hdr, p_data, np_data, cpl_data} !== 60'h0) begin
      miscompares++; $display("FAIL reset_credits got %h required 0", {p_hdr, np_hdr, cpl_hdr, p_data, np_data, cpl_data});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset got %b required 1", bus.s_axis_tready); end
  endtask

  task automatic test_init_fc1;
    send_dllp(8'h40, 8'h01, 12'h040, 16'h0);
    vectors++;
    if (p_hdr !== 8'h01 || p_data !== 12'h040) begin
      miscompares++; $display("FAIL initfc1_p got hdr=%h data=%h required hdr=01 data=040", p_hdr, p_data);
    end
    vectors++;
    if (fc1 !== 1'b0) begin miscompares++; $display("FAIL fc1_early got %b required 0", fc1); end
    send_dllp(8'h50, 8'h01, 12'h001, 16'h0);
    send_dllp(8'h60, 8'h00, 12'h000, 16'h0);
    vectors++;
    if (fc1 !== 1'b1) begin miscompares++; $display("FAIL fc1_set got %b required 1", fc1); end
    vectors++;
    if (np_hdr !== 8'h01 || np_data !== 12'h001 || cpl_hdr !== 8'h00 || cpl_data !== 12'h000) begin
      miscompares++; $display("FAIL initfc1_np_cpl got np=%h/%h cpl=%h/%h required 01/001 00/000", np_hdr, np_data, cpl_hdr, cpl_data);
    end
  endtask

  task automatic test_fc2_update;
    send_dllp(8'hC0, 8'h10, 12'h100, 16'h0);
    vectors++;
    if (fc2 !== 1'b1) begin miscompares++; $display("FAIL fc2_set got %b required 1", fc2); end
    vectors++;
    if (p_hdr !== 8'h01 || p_data !== 12'h040 || update_valid !== 1'b0) begin
      miscompares++; $display("FAIL initfc2_locked got hdr=%h data=%h upd=%b required 01 040 0", p_hdr, p_data, update_valid);
    end
    send_dllp(8'h80, 8'h20, 12'h200, 16'h0);
    vectors++;
    if (p_hdr !== 8'h20 || p_data !== 12'h200) begin
      miscompares++; $display("FAIL updatefc_p got hdr=%h data=%h required 20 200", p_hdr, p_data);
    end
    vectors++;
    if (update_valid !== 1'b1) begin miscompares++; $display("FAIL update_pulse got %b required 1", update_valid); end
    @(posedge clk); #1;
    vectors++;
    if (update_valid !== 1'b0) begin miscompares++; $display("FAIL update_pulse_end got %b required 0", update_valid); end
  endtask

  task automatic test_back_to_back;
    send_dllp(8'h90, 8'hA5, 12'h5A5, 16'h0);
    vectors++;
    if (np_hdr !== 8'hA5 || np_data !== 12'h5A5 || update_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_np got hdr=%h data=%h upd=%b required A5 5A5 1", np_hdr, np_data, update_valid);
    end
    send_dllp(8'hA0, 8'h3C, 12'hFFF, 16'h0);
    vectors++;
    if (cpl_hdr !== 8'h3C || cpl_data !== 12'hFFF || update_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_cpl got hdr=%h data=%h upd=%b required 3C FFF 1", cpl_hdr, cpl_data, update_valid);
    end
  endtask

  task automatic test_crc_err;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    vectors++;
    if ({fc1, fc2} !== 2'b00 || p_hdr !== 8'h00 || cpl_data !== 12'h000) begin
      miscompares++; $display("FAIL clear_state got fc=%b p_hdr=%h cpl_data=%h required 00 00 000", {fc1, fc2}, p_hdr, cpl_data);
    end
    send_dllp(8'h40, 8'h01, 12'h040, 16'h0001);
    vectors++;
    if (crc_err !== 1'b1) begin miscompares++; $display("FAIL crc_err_pulse got %b required 1", crc_err); end
    vectors++;
    if (p_hdr !== 8'h00 || p_data !== 12'h000) begin
      miscompares++; $display("FAIL crc_err_dropped got hdr=%h data=%h required 00 000", p_hdr, p_data);
    end
    send_dllp(8'h40, 8'h05, 12'h123, 16'h0);
    vectors++;
    if (p_hdr !== 8'h05 || p_data !== 12'h123 || crc_err !== 1'b0) begin
      miscompares++; $display("FAIL after_crc_err got hdr=%h data=%h err=%b required 05 123 0", p_hdr, p_data, crc_err);
    end
  endtask

  task automatic test_frame_err;
    logic [31:0] body;
    int          pulses;
    send_beat(32'hDEAD_BEEF, 1'b1);
    vectors++;
    if (frame_err !== 1'b1) begin miscompares++; $display("FAIL frame_err_body_last got %b required 1", frame_err); end
    body   = make_body(8'h50, 8'h07, 12'h077);
    pulses = 0;
    send_beat(body, 1'b0);          pulses += int'(frame_err);
    send_beat(32'h1111_1111, 1'b0); pulses += int'(frame_err);
    send_beat(32'h2222_2222, 1'b0); pulses += int'(frame_err);
    send_beat({16'h0, ref_crc(body)}, 1'b1); pulses += int'(frame_err);
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL frame_err_count got %0d required 1", pulses); end
    vectors++;
    if (np_hdr !== 8'h00 || np_data !== 12'h000) begin
      miscompares++; $display("FAIL frame_drop got np=%h/%h required 00/000", np_hdr, np_data);
    end
    send_dllp(8'h50, 8'h07, 12'h077, 16'h0);
    vectors++;
    if (np_hdr !== 8'h07 || np_data !== 12'h077 || frame_err !== 1'b0) begin
      miscompares++; $display("FAIL after_frame_err got np=%h/%h ferr=%b required 07/077 0", np_hdr, np_data, frame_err);
    end
  endtask

  task automatic test_vc;
    send_dllp(8'h61, 8'h03, 12'h033, 16'h0);
    vectors++;
    if (cpl_hdr !== 8'h00 || fc1 !== 1'b0 || crc_err !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++; $display("FAIL wrong_vc got cpl_hdr=%h fc1=%b errs=%b%b required 00 0 00", cpl_hdr, fc1, crc_err, frame_err);
    end
    send_dllp(8'h60, 8'h03, 12'h033, 16'h0);
    vectors++;
    if (cpl_hdr !== 8'h03 || cpl_data !== 12'h033 || fc1 !== 1'b1) begin
      miscompares++; $display("FAIL right_vc got cpl=%h/%h fc1=%b required 03/033 1", cpl_hdr, cpl_data, fc1);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] body;
    body = make_body(8'h40, 8'h09, 12'h099);
    send_beat(body, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (fc1 !== 1'b0 || p_hdr !== 8'h00 || bus.s_axis_tready !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got fc1=%b p_hdr=%h tready=%b required 0 00 0", fc1, p_hdr, bus.s_axis_tready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat({16'h0, ref_crc(body)}, 1'b1);
    vectors++;
    if (frame_err !== 1'b1 || p_hdr !== 8'h00 || crc_err !== 1'b0) begin
      miscompares++; $display("FAIL crc_after_reset got ferr=%b p_hdr=%h cerr=%b required 1 00 0", frame_err, p_hdr, crc_err);
    end
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rst               = 1'b1;
    clear             = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = '0;
    #1;
    test_reset();
    test_init_fc1();
    test_fc2_update();
    test_back_to_back();
    test_crc_err();
    test_frame_err();
    test_vc();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
